// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands a cipher key into 11 stored round keys,
// one per clock, using an external combinational 32-bit S-box.
module aes_key_expand #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init,
    input  logic [KEY_W-1:0] key,
    input  logic [3:0]       round,
    output logic [KEY_W-1:0] round_key,
    output logic [31:0]      sbox_in,
    input  logic [31:0]      sbox_out,
    output logic             ready,
    output logic             keys_valid
);

    typedef enum logic {
        IDLE,
        GEN
    } state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t           state;
    logic [KEY_W-1:0] rk [0:NR];
    logic [KEY_W-1:0] prev;
    logic [3:0]       idx;
    logic [7:0]       rcon;

    logic [31:0]      t;
    logic [31:0]      n0;
    logic [31:0]      n1;
    logic [31:0]      n2;
    logic [31:0]      n3;
    logic [KEY_W-1:0] next_key;
    logic [7:0]       rcon_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // RotWord of the previous key's last word goes out to the S-box
    assign sbox_in = {prev[23:0], prev[31:24]};

    // Next round key from the previous one and the substituted word
    always_comb begin
        t         = sbox_out ^ {rcon, 24'h0};
        n0        = prev[127:96] ^ t;
        n1        = prev[95:64] ^ n0;
        n2        = prev[63:32] ^ n1;
        n3        = prev[31:0] ^ n2;
        next_key  = {n0, n1, n2, n3};
        rcon_next = xtime(rcon);
    end

    // Combinational read port; indices past the last key read as zero
    always_comb begin
        round_key = '0;
        if (round <= LAST) begin
            round_key = rk[round];
        end
    end

    // Schedule FSM: latch key on init, then write one round key per cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ready      <= 1'b1;
            keys_valid <= 1'b0;
            idx        <= 4'd0;
            rcon       <= 8'h01;
            prev       <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (init && ready) begin
                        rk[0]      <= key;
                        prev       <= key;
                        idx        <= 4'd1;
                        rcon       <= 8'h01;
                        ready      <= 1'b0;
                        keys_valid <= 1'b0;
                        state      <= GEN;
                    end
                end
                GEN: begin
                    rk[idx] <= next_key;
                    prev    <= next_key;
                    rcon    <= rcon_next;
                    if (idx == LAST) begin
                        ready      <= 1'b1;
                        keys_valid <= 1'b1;
                        idx        <= 4'd0;
                        state      <= IDLE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus queues expected schedules,
// a negedge monitor checks them when keys_valid rises.
module tb_aes_key_expand;

    logic         clk;
    logic         reset_n;
    logic         init;
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic         ready;
    logic         keys_valid;

    aes_key_expand #(.NR(10), .KEY_W(128)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .key       (key),
        .round     (round),
        .round_key (round_key),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .ready     (ready),
        .keys_valid(keys_valid)
    );

    localparam logic [127:0] FK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        int           id;
        logic [127:0] k0;
        logic [127:0] k1;
        logic [127:0] k10;
        int           done_cyc;
        int           fall_cyc;
        bit           chk_fall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fall_seen = -1;
    bit   idle_req = 0;
    int   next_id = 0;

    initial clk = 0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] yy;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            yy = 8'(y);
            if (gmul(x, yy) == 8'h01) inv = yy;
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
               ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]), sbox_byte(w[7:0])};
    endfunction

    assign sbox_out = sub_word(sbox_in);

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: checks a queued schedule on each keys_valid rise
    initial begin
        exp_t e;
        bit   kv_q;
        kv_q  = 1'b0;
        round = 4'd0;
        forever begin
            @(negedge clk);
            if (!keys_valid && kv_q) fall_seen = cyc;
            if (keys_valid && !kv_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_keys_valid", 128'(keys_valid), 128'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("s%0d_done_cyc", e.id), 128'(cyc),
                        128'(e.done_cyc));
                    if (e.chk_fall)
                        chk($sformatf("s%0d_fall_cyc", e.id),
                            128'(fall_seen), 128'(e.fall_cyc));
                    chk($sformatf("s%0d_ready", e.id), 128'(ready), 128'd1);
                    chk($sformatf("s%0d_sbox_in", e.id), 128'(sbox_in),
                        128'({e.k10[23:0], e.k10[31:24]}));
                    round = 4'd0;
                    #1 chk($sformatf("s%0d_rk0", e.id), round_key, e.k0);
                    round = 4'd1;
                    #1 chk($sformatf("s%0d_rk1", e.id), round_key, e.k1);
                    round = 4'd10;
                    #1 chk($sformatf("s%0d_rk10", e.id), round_key, e.k10);
                    round = 4'd11;
                    #1 chk($sformatf("s%0d_rk11", e.id), round_key, 128'h0);
                    round = 4'd15;
                    #1 chk($sformatf("s%0d_rk15", e.id), round_key, 128'h0);
                end
            end
            kv_q = keys_valid;
            if (idle_req) begin
                idle_req = 0;
                chk("idle_ready", 128'(ready), 128'd1);
                chk("idle_keys_valid", 128'(keys_valid), 128'd0);
                chk("idle_sbox_in", 128'(sbox_in), 128'h0);
                for (int r = 0; r < 16; r++) begin
                    round = 4'(r);
                    #1 chk($sformatf("idle_rk%0d", r), round_key, 128'h0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [127:0] k, input logic [127:0] k1,
                           input logic [127:0] k10, input bit push,
                           input bit chk_fall);
        exp_t e;
        init = 1'b1;
        key  = k;
        step();
        init = 1'b0;
        key  = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (push) begin
            e.id       = next_id;
            e.k0       = k;
            e.k1       = k1;
            e.k10      = k10;
            e.done_cyc = cyc + 10;
            e.fall_cyc = cyc;
            e.chk_fall = chk_fall;
            sb.push_back(e);
            next_id++;
        end
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within %0d", budget);
        end
    endtask

    // Stimulus
    initial begin
        reset_n = 1'b0;
        init    = 1'b0;
        key     = '0;
        repeat (2) step();
        reset_n  = 1'b1;
        idle_req = 1;
        step();

        do_init(FK, FK1, FK10, 1, 0);
        wait_ready(20);

        do_init(128'h0, ZK1, ZK10, 1, 1);
        wait_ready(20);
        step();

        do_init(FK, FK1, FK10, 1, 1);
        repeat (3) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        init = 1'b1;
        key  = 128'h0;
        step();
        init = 1'b0;
        wait_ready(20);
        step();

        do_init(FK, FK1, FK10, 0, 0);
        repeat (4) step();
        reset_n = 1'b0;
        step();
        reset_n  = 1'b1;
        idle_req = 1;
        step();
        do_init(FK, FK1, FK10, 1, 0);
        wait_ready(20);
        step();

        reset_n = 1'b0;
        init    = 1'b1;
        key     = FK;
        step();
        reset_n  = 1'b1;
        init     = 1'b0;
        idle_req = 1;
        repeat (14) step();

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

endmodule
